// File: rtl/vga_timing_xga.sv
// VGA raster timing generator, default 1024x768@60 (65 MHz pixel clock).
// Ports: clk, rst (sync, active-high); hcount/vcount 11-bit counters;
//        hsync/vsync (SYNC_ACTIVE when asserted); hblnk/vblnk; frame_start.
// All outputs are flops whose values match the same-cycle counter values.
module vga_timing_xga #(
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned H_FP        = 24,
    parameter int unsigned H_SYNC      = 136,
    parameter int unsigned H_BP        = 160,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned V_FP        = 3,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_BP        = 29,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
            $error("vga_timing_xga: H_TOTAL/V_TOTAL exceed 11-bit counters");
        end
    endgenerate

    // 12-bit boundaries so a sync end equal to 2048 still compares correctly
    localparam logic [11:0] HA   = 12'(H_ACTIVE);
    localparam logic [11:0] HSS  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HSE  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VA   = 12'(V_ACTIVE);
    localparam logic [11:0] VSS  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VSE  = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] HMAX = 11'(H_TOTAL - 1);
    localparam logic [10:0] VMAX = 11'(V_TOTAL - 1);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_frame_start;

    logic        w_hwrap;
    logic [10:0] w_hnext;
    logic [10:0] w_vnext;
    logic [11:0] w_hn12;
    logic [11:0] w_vn12;
    logic        w_hs_on;
    logic        w_vs_on;

    // Flags decode the next counter values so they land in the same
    // cycle as the counts they describe.
    always_comb begin
        w_hwrap = (r_hcount == HMAX);
        w_hnext = r_hcount + 11'd1;
        w_vnext = r_vcount;
        if (w_hwrap) begin
            w_hnext = '0;
            if (r_vcount == VMAX) begin
                w_vnext = '0;
            end else begin
                w_vnext = r_vcount + 11'd1;
            end
        end
        w_hn12  = {1'b0, w_hnext};
        w_vn12  = {1'b0, w_vnext};
        w_hs_on = (w_hn12 >= HSS) && (w_hn12 < HSE);
        w_vs_on = (w_vn12 >= VSS) && (w_vn12 < VSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b1;
        end else begin
            r_hcount      <= w_hnext;
            r_vcount      <= w_vnext;
            r_hsync       <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_hblnk       <= (w_hn12 >= HA);
            r_vblnk       <= (w_vn12 >= VA);
            r_frame_start <= (w_hnext == 11'd0) && (w_vnext == 11'd0);
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_xga.sv
// Bench for vga_timing_xga: default XGA instance plus two scaled-down
// instances (both sync polarities) checked against an arithmetic raster model.
module tb_vga_timing_xga;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [10:0] xh, xv, ah, av, bh, bv;
    logic        xhs, xvs, xhb, xvb, xfs;
    logic        ahs, avs, ahb, avb, afs;
    logic        bhs, bvs, bhb, bvb, bfs;

    vga_timing_xga u_xga (
        .clk(clk), .rst(rst), .hcount(xh), .vcount(xv),
        .hsync(xhs), .vsync(xvs), .hblnk(xhb), .vblnk(xvb),
        .frame_start(xfs)
    );

    vga_timing_xga #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE(1'b0)
    ) u_sm0 (
        .clk(clk), .rst(rst), .hcount(ah), .vcount(av),
        .hsync(ahs), .vsync(avs), .hblnk(ahb), .vblnk(avb),
        .frame_start(afs)
    );

    vga_timing_xga #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE(1'b1)
    ) u_sm1 (
        .clk(clk), .rst(rst), .hcount(bh), .vcount(bv),
        .hsync(bhs), .vsync(bvs), .hblnk(bhb), .vblnk(bvb),
        .frame_start(bfs)
    );

    logic [26:0] got [3];
    assign got[0] = {ah, av, ahs, avs, ahb, avb, afs};
    assign got[1] = {bh, bv, bhs, bvs, bhb, bvb, bfs};
    assign got[2] = {xh, xv, xhs, xvs, xhb, xvb, xfs};

    // cycles elapsed since the last clock edge that saw rst high
    longint t = 0;
    always @(posedge clk) t <= rst ? 64'd0 : t + 64'd1;

    // Raster position follows directly from elapsed time.
    function automatic logic [26:0] exp_vec(int idx, longint tt);
        int ha, hf, hs, hb, va, vf, vs, vb, htot, vtot, h, v;
        logic sa, ohs, ovs;
        if (idx == 2) begin
            ha = 1024; hf = 24; hs = 136; hb = 160;
            va = 768;  vf = 3;  vs = 6;   vb = 29;
            sa = 1'b0;
        end else begin
            ha = 16; hf = 2; hs = 4; hb = 3;
            va = 10; vf = 1; vs = 2; vb = 3;
            sa = (idx == 1);
        end
        htot = ha + hf + hs + hb;
        vtot = va + vf + vs + vb;
        h = int'(tt % longint'(htot));
        v = int'((tt / longint'(htot)) % longint'(vtot));
        ohs = (h >= ha + hf && h < ha + hf + hs) ? sa : ~sa;
        ovs = (v >= va + vf && v < va + vf + vs) ? sa : ~sa;
        return {11'(h), 11'(v), ohs, ovs, (h >= ha), (v >= va),
                (h == 0 && v == 0)};
    endfunction

    task automatic pulse_rst(int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] w;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                w = exp_vec(i, 0);
                total++;
                if (got[i] !== w) begin
                    bad++;
                    $display("FAIL rst_hold%0d got=%h want=%h", i, got[i], w);
                end
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (got[2] !== {11'd0, 11'd0, 5'b11001}) begin
            bad++;
            $display("FAIL rst_c0 got=%h want=%h", got[2],
                     {11'd0, 11'd0, 5'b11001});
        end
        total++;
        if (got[1] !== {11'd0, 11'd0, 5'b00001}) begin
            bad++;
            $display("FAIL rst_c0_pos got=%h want=%h", got[1],
                     {11'd0, 11'd0, 5'b00001});
        end
        @(negedge clk);
        total++;
        if (got[2] !== {11'd1, 11'd0, 5'b11000}) begin
            bad++;
            $display("FAIL rst_c1 got=%h want=%h", got[2],
                     {11'd1, 11'd0, 5'b11000});
        end
    endtask

    task automatic test_line();
        int rise_h = -1, lo = 9999, hi = -1, lowcnt = 0;
        logic prev_hb = 1'b0;
        logic [26:0] w;
        pulse_rst(1);
        for (int c = 0; c <= 1344; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                w = exp_vec(i, t);
                total++;
                if (got[i] !== w) begin
                    bad++;
                    $display("FAIL line_sb%0d t=%0d got=%h want=%h",
                             i, t, got[i], w);
                end
            end
            if (c < 1344) begin
                if (xhb && !prev_hb) rise_h = int'(xh);
                prev_hb = xhb;
                if (xhs == 1'b0) begin
                    lowcnt++;
                    if (int'(xh) < lo) lo = int'(xh);
                    if (int'(xh) > hi) hi = int'(xh);
                end
            end else begin
                total++;
                if ({xh, xv, xhb} !== {11'd0, 11'd1, 1'b0}) begin
                    bad++;
                    $display("FAIL line_wrap got h=%0d v=%0d hb=%b want 0 1 0",
                             xh, xv, xhb);
                end
            end
        end
        total++;
        if (rise_h != 1024) begin
            bad++;
            $display("FAIL hblnk_rise got=%0d want=1024", rise_h);
        end
        total++;
        if (lowcnt != 136 || lo != 1048 || hi != 1183) begin
            bad++;
            $display("FAIL hsync_win got=%0d..%0d n=%0d want=1048..1183 n=136",
                     lo, hi, lowcnt);
        end
    endtask

    task automatic test_frame();
        int vb_n = 0, vs0_n = 0, vs1_n = 0;
        logic [26:0] w;
        pulse_rst(1);
        for (int c = 0; c <= 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                w = exp_vec(i, t);
                total++;
                if (got[i] !== w) begin
                    bad++;
                    $display("FAIL frame_sb%0d t=%0d got=%h want=%h",
                             i, t, got[i], w);
                end
            end
            if (c < 400) begin
                if (avb) vb_n++;
                if (!avs) vs0_n++;
                if (bvs) vs1_n++;
            end
            if (c == 399) begin
                total++;
                if ({ah, av} !== {11'd24, 11'd15}) begin
                    bad++;
                    $display("FAIL frame_last got=%0d,%0d want=24,15", ah, av);
                end
            end
            if (c == 400) begin
                total++;
                if ({ah, av, afs} !== {11'd0, 11'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL frame_wrap got=%0d,%0d fs=%b want=0,0,1",
                             ah, av, afs);
                end
            end
        end
        total++;
        if (vb_n != 150) begin
            bad++;
            $display("FAIL vblnk_len got=%0d want=150", vb_n);
        end
        total++;
        if (vs0_n != 50 || vs1_n != 50) begin
            bad++;
            $display("FAIL vsync_len got=%0d/%0d want=50/50", vs0_n, vs1_n);
        end
    endtask

    task automatic test_period();
        int pulses[$];
        pulse_rst(1);
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            if (afs) pulses.push_back(c);
        end
        total++;
        if (pulses.size() != 4) begin
            bad++;
            $display("FAIL fs_count got=%0d want=4", pulses.size());
        end
        for (int k = 1; k < pulses.size(); k++) begin
            total++;
            if (pulses[k] - pulses[k-1] != 400) begin
                bad++;
                $display("FAIL fs_period got=%0d want=400",
                         pulses[k] - pulses[k-1]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [26:0] w;
        for (int r = 0; r < 7; r++) begin
            // first round lands at the scaled analogue of (600,400): (12,7)
            n = (r == 0) ? 188 : int'($urandom_range(1, 900));
            pulse_rst(1);
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    w = exp_vec(i, t);
                    total++;
                    if (got[i] !== w) begin
                        bad++;
                        $display("FAIL mid_sb%0d t=%0d got=%h want=%h",
                                 i, t, got[i], w);
                    end
                end
            end
            if (r == 0) begin
                total++;
                if ({ah, av} !== {11'd12, 11'd7}) begin
                    bad++;
                    $display("FAIL mid_pos got=%0d,%0d want=12,7", ah, av);
                end
            end
            pulse_rst(int'($urandom_range(1, 3)));
            @(negedge clk);
            total++;
            if (got[0] !== {11'd0, 11'd0, 5'b11001}) begin
                bad++;
                $display("FAIL mid_rst_c0 got=%h want=%h", got[0],
                         {11'd0, 11'd0, 5'b11001});
            end
            @(negedge clk);
            total++;
            if (got[0] !== {11'd1, 11'd0, 5'b11000}) begin
                bad++;
                $display("FAIL mid_rst_c1 got=%h want=%h", got[0],
                         {11'd1, 11'd0, 5'b11000});
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_period();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
